// File: rtl/klingon_segment_decoder.sv
// Receive side of the Klingon display link: deserialises 7 segment bits (MSB first)
// and decodes the glyph to a BCD digit, flagging unknown glyphs and abandoned symbols.
module klingon_segment_decoder #(
    parameter int TIMEOUT   = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seg_bit,
    input  logic                 seg_valid,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 glyph_err,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [5:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [3:0]           digit_q, digit_d;
    logic                 digit_valid_q, digit_valid_d;
    logic                 glyph_err_q, glyph_err_d;
    logic                 frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [6:0]           shift_next;
    logic [4:0]           lut;
    logic                 err_inc;

    // Returns {hit, digit}
    function automatic logic [4:0] glyph_lookup(input logic [6:0] y);
        case (y)
            7'h01:   glyph_lookup = 5'h10;
            7'h30:   glyph_lookup = 5'h11;
            7'h38:   glyph_lookup = 5'h12;
            7'h3C:   glyph_lookup = 5'h13;
            7'h3E:   glyph_lookup = 5'h14;
            7'h4F:   glyph_lookup = 5'h15;
            7'h5B:   glyph_lookup = 5'h16;
            7'h66:   glyph_lookup = 5'h17;
            7'h6D:   glyph_lookup = 5'h18;
            7'h7F:   glyph_lookup = 5'h19;
            default: glyph_lookup = 5'h00;
        endcase
    endfunction

    // The decode happens as the 7th bit is accepted so the registered result is
    // visible during the DONE cycle, one cycle after the last bit.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        gap_d         = gap_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        glyph_err_d   = 1'b0;
        frame_err_d   = 1'b0;
        err_count_d   = err_count_q;
        err_inc       = 1'b0;
        shift_next    = {shift_q, seg_bit};
        lut           = glyph_lookup(shift_next);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (seg_valid) begin
                    shift_d   = {5'b0, seg_bit};
                    bit_cnt_d = 3'd1;
                    gap_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (seg_valid) begin
                    gap_d = '0;
                    if (bit_cnt_q == 3'd6) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = DONE;
                        if (lut[4]) begin
                            digit_d       = lut[3:0];
                            digit_valid_d = 1'b1;
                        end else begin
                            glyph_err_d = 1'b1;
                            err_inc     = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_next[5:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    err_inc     = 1'b1;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    gap_d       = '0;
                    state_d     = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_inc && (err_count_q != {ERR_CNT_W{1'b1}}))
            err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            gap_q         <= '0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            glyph_err_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_q         <= gap_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            glyph_err_q   <= glyph_err_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign glyph_err   = glyph_err_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q == SHIFT);
endmodule

// File: tb/tb_klingon_segment_decoder.sv
// Bench for klingon_segment_decoder: glyph table vectors, hand-built corner sequences,
// and random traffic checked cycle by cycle against a symbol-level model.
module tb_klingon_segment_decoder;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset, seg_bit, seg_valid;
    logic [3:0] digit, digit2;
    logic digit_valid, glyph_err, frame_err, busy;
    logic digit_valid2, glyph_err2, frame_err2, busy2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    always #5 clk = ~clk;

    klingon_segment_decoder #(.TIMEOUT(TIMEOUT), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .seg_bit(seg_bit), .seg_valid(seg_valid),
        .digit(digit), .digit_valid(digit_valid), .glyph_err(glyph_err),
        .frame_err(frame_err), .err_count(err_count), .busy(busy));

    klingon_segment_decoder #(.TIMEOUT(TIMEOUT), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .seg_bit(seg_bit), .seg_valid(seg_valid),
        .digit(digit2), .digit_valid(digit_valid2), .glyph_err(glyph_err2),
        .frame_err(frame_err2), .err_count(err_count2), .busy(busy2));

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] glyphs [10] = '{7'h01, 7'h30, 7'h38, 7'h3C, 7'h3E,
                                7'h4F, 7'h5B, 7'h66, 7'h6D, 7'h7F};

    // Model: a symbol is just a list of accepted bits plus an idle-gap count
    int         m_n, m_gap, m_err;
    logic [6:0] m_acc;
    logic [3:0] m_digit;
    logic       m_dv, m_ge, m_fe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int e, input int mx);
        return (e > mx) ? mx : e;
    endfunction

    task automatic model_step(input logic v, input logic b, input logic r);
        int idx;
        m_dv = 0; m_ge = 0; m_fe = 0;
        if (r) begin
            m_n = 0; m_gap = 0; m_err = 0; m_acc = '0; m_digit = '0;
        end else if (m_n == 0) begin
            if (v) begin m_acc = {6'b0, b}; m_n = 1; m_gap = 0; end
        end else if (v) begin
            m_acc = {m_acc[5:0], b};
            m_n++;
            m_gap = 0;
            if (m_n == 7) begin
                idx = -1;
                for (int i = 0; i < 10; i++) if (glyphs[i] == m_acc) idx = i;
                if (idx >= 0) begin m_dv = 1; m_digit = 4'(idx); end
                else begin m_ge = 1; m_err++; end
                m_n = 0;
            end
        end else begin
            m_gap++;
            if (m_gap == TIMEOUT) begin m_fe = 1; m_err++; m_n = 0; m_gap = 0; end
        end
    endtask

    task automatic check_all();
        chk("digit", 32'(digit), 32'(m_digit));
        chk("digit_valid", 32'(digit_valid), 32'(m_dv));
        chk("glyph_err", 32'(glyph_err), 32'(m_ge));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("busy", 32'(busy), 32'(m_n > 0));
        chk("err_count", 32'(err_count), 32'(sat(m_err, 255)));
        chk("err_count_w2", 32'(err_count2), 32'(sat(m_err, 3)));
        chk("digit_w2", 32'(digit2), 32'(m_digit));
        chk("pulse_excl", 32'((32'(digit_valid) + 32'(glyph_err) + 32'(frame_err)) <= 1), 32'd1);
    endtask

    task automatic tick(input logic v, input logic b, input logic r = 1'b0);
        seg_valid = v; seg_bit = b; reset = r;
        @(posedge clk);
        model_step(v, b, r);
        #1;
        check_all();
    endtask

    task automatic send_code(input logic [6:0] code, input int gap);
        for (int i = 6; i >= 0; i--) begin
            tick(1'b1, code[i]);
            if (i > 0) for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    typedef struct {
        logic [6:0] code;
        logic       good;
        logic [3:0] exp_digit;
        int         exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        for (int i = 0; i < 10; i++) vecs[i] = '{glyphs[i], 1'b1, 4'(i), 0};
        vecs[10] = '{7'h7E, 1'b0, 4'd9, 1};
        vecs[11] = '{7'h00, 1'b0, 4'd9, 2};

        seg_valid = 0; seg_bit = 0; reset = 1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_dv", 32'(digit_valid), 32'd0);

        // single 8
        send_code(7'h6D, 0);
        chk("t1_dv", 32'(digit_valid), 32'd1);
        chk("t1_digit", 32'(digit), 32'd8);
        chk("t1_err", 32'(err_count), 32'd0);
        tick(1'b0, 1'b0);
        chk("t1_dv_pulse", 32'(digit_valid), 32'd0);

        // table: 0..9 back-to-back, then two bad glyphs
        for (int i = 0; i < 12; i++) begin
            send_code(vecs[i].code, 0);
            chk("tbl_dv", 32'(digit_valid), 32'(vecs[i].good));
            chk("tbl_ge", 32'(glyph_err), 32'(!vecs[i].good));
            chk("tbl_digit", 32'(digit), 32'(vecs[i].exp_digit));
            chk("tbl_err", 32'(err_count), 32'(vecs[i].exp_err));
        end

        // abandoned symbol: 3 bits of 3C then TIMEOUT idle cycles
        tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        for (int g = 0; g < TIMEOUT - 1; g++) tick(1'b0, 1'b1);
        chk("t4_no_fe_early", 32'(frame_err), 32'd0);
        chk("t4_busy_early", 32'(busy), 32'd1);
        tick(1'b0, 1'b0);
        chk("t4_fe", 32'(frame_err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_err", 32'(err_count), 32'd3);
        send_code(7'h30, 0);
        chk("t4_digit", 32'(digit), 32'd1);
        chk("t4_dv", 32'(digit_valid), 32'd1);

        // gaps just under the timeout
        send_code(7'h5B, TIMEOUT - 1);
        chk("t5_dv", 32'(digit_valid), 32'd1);
        chk("t5_digit", 32'(digit), 32'd6);
        chk("t5_err", 32'(err_count), 32'd3);

        // reset mid-symbol, then saturate the narrow counter
        tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("t6_err", 32'(err_count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_digit", 32'(digit), 32'd0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_code(7'h7E, 0);
        chk("t6_sat", 32'(err_count2), 32'd3);
        chk("t6_err5", 32'(err_count), 32'd5);

        // random traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_code(glyphs[$urandom_range(0, 9)],
                                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 17))
                                                                  : int'($urandom_range(0, 2)));
                4:          send_code(7'($urandom), 0);
                5:          tick(1'b0, 1'b0, ($urandom_range(0, 19) == 0));
                default:    tick(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
